afifo_wr_arbiter: RTL and testbench

//   Shares the single write port of the async FIFO among N_REQ producers in the write clock domain.

---
 rtl/afifo_pkg.sv | 22 ++
 rtl/rr_pick.sv | 34 +++
 rtl/afifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_afifo_wr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// ============================================================================
// Module  : afifo_pkg
// Brief   : Shared types and sizing helpers for the async-FIFO write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package afifo_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Index width for N requesters; never collapses to zero bits.
   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : afifo_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Rotate-priority encoder; first asserted request after last_owner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import afifo_pkg::*;
#(
   parameter int  N_REQ = 4,
   localparam int OW    = owner_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [OW-1:0]    last_owner_i,
   output logic             valid_o,
   output logic [OW-1:0]    idx_o
);

   // Walk from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req_i[(int'(last_owner_i) + k) % N_REQ]) begin
            valid_o = 1'b1;
            idx_o   = OW'((int'(last_owner_i) + k) % N_REQ);
         end
      end
   end

endmodule : rr_pick

`default_nettype wire

// File: rtl/afifo_wr_arbiter.sv
// ============================================================================
// Module  : afifo_wr_arbiter
// Brief   : Packet-granular round-robin arbiter feeding the async FIFO write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module afifo_wr_arbiter
   import afifo_pkg::*;
#(
   parameter int  N_REQ     = 4,
   parameter int  DATA_W    = 8,
   parameter int  MAX_BURST = 4,
   localparam int OWNER_W   = owner_w(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   input  logic                      wfull,
   output logic [N_REQ-1:0]          gnt,
   output logic                      winc,
   output logic [DATA_W-1:0]         wdata,
   output logic [OWNER_W-1:0]        owner,
   output logic                      busy
);

   localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]   BURST_END = CNT_W'(MAX_BURST - 1);

   arb_state_t           state_q, state_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
   logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;

   logic                 w_pick_valid;
   logic [OWNER_W-1:0]   w_pick_idx;
   logic                 w_xfer;
   logic [DATA_W-1:0]    w_owner_data;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req_i        (req),
      .last_owner_i (last_owner_q),
      .valid_o      (w_pick_valid),
      .idx_o        (w_pick_idx)
   );

   assign w_owner_data = req_data[owner_q*DATA_W +: DATA_W];
   assign w_xfer       = (state_q == GRANT) & req[owner_q] & ~wfull;

   assign owner = owner_q;
   assign busy  = (state_q == GRANT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= OWNER_W'(N_REQ - 1);
         burst_cnt_q  <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         wdata_q      <= wdata_d;
      end
   end

   // wdata follows the accepted word and otherwise replays the last one written.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      wdata_d      = wdata_q;
      gnt          = '0;
      winc         = 1'b0;
      wdata        = wdata_q;

      case (state_q)
         IDLE: begin
            if (w_pick_valid) begin
               owner_d = w_pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (w_xfer) begin
               winc         = 1'b1;
               gnt[owner_q] = 1'b1;
               wdata        = w_owner_data;
               wdata_d      = w_owner_data;
               burst_cnt_d  = burst_cnt_q + CNT_W'(1);
            end
            // A full FIFO stalls in place; only a withdrawn request can end the grant then.
            if (!req[owner_q] ||
                (w_xfer && (req_last[owner_q] || (burst_cnt_q == BURST_END)))) begin
               state_d      = IDLE;
               last_owner_d = owner_q;
               burst_cnt_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule : afifo_wr_arbiter

`default_nettype wire

// File: tb/tb_afifo_wr_arbiter.sv
// ============================================================================
// Module  : tb_afifo_wr_arbiter
// Brief   : Scoreboard bench for afifo_wr_arbiter with queue-backed producers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_afifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int OW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic            wfull;
   logic [N-1:0]    gnt;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic [OW-1:0]   owner;
   logic            busy;

   afifo_wr_arbiter #(
      .N_REQ     (N),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .wfull    (wfull),
      .gnt      (gnt),
      .winc     (winc),
      .wdata    (wdata),
      .owner    (owner),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int data;
      int gap;
   } exp_t;

   exp_t         sb[$];
   logic [8:0]   pq [N][$];
   logic [N-1:0] en;
   logic [N-1:0] gnt_s;
   int           checks   = 0;
   int           errors   = 0;
   int           cyc      = 0;
   int           last_cyc = 0;
   int           wr_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic update_inputs();
      for (int i = 0; i < N; i++) begin
         if (en[i] && pq[i].size() > 0) begin
            req[i]              = 1'b1;
            req_last[i]         = pq[i][0][8];
            req_data[i*DW +: DW] = pq[i][0][7:0];
         end else begin
            req[i]              = 1'b0;
            req_last[i]         = 1'b0;
            req_data[i*DW +: DW] = '0;
         end
      end
   endtask

   task automatic add_pkt(input int i, input int base, input int n);
      for (int k = 0; k < n; k++)
         pq[i].push_back({(k == n - 1), 8'(base + k)});
      update_inputs();
   endtask

   task automatic expect_w(input int idx, input int data, input int gap);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   function automatic bit pq_empty();
      for (int i = 0; i < N; i++)
         if (pq[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) pq[i].delete();
      sb.delete();
      en    = '1;
      wfull = 1'b0;
      update_inputs();
      #1;
      chk("rst_winc",  winc,  0);
      chk("rst_gnt",   gnt,   0);
      chk("rst_busy",  busy,  0);
      chk("rst_owner", owner, 0);
      chk("rst_wdata", wdata, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((sb.size() > 0 || !pq_empty()) && n < budget) begin
         step();
         n++;
      end
      chk("done_in_time", int'(n < budget), 1);
      repeat (2) step();
   endtask

   task automatic wait_writes(input int target, input int budget);
      int n = 0;
      while (wr_count < target && n < budget) begin
         step();
         n++;
      end
      chk("writes_reached", int'(wr_count >= target), 1);
   endtask

   // Monitor: samples mid-cycle and pops the scoreboard on every FIFO write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         gnt_s = gnt;
         if (rst_n) begin
            if (!winc && gnt != '0) chk("gnt_without_winc", gnt, 0);
            if (winc) begin
               wr_count++;
               chk("winc_vs_wfull", wfull, 0);
               chk("sb_has_entry", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("gnt",   gnt,   1 << e.idx);
                  chk("wdata", wdata, e.data);
                  chk("owner", owner, e.idx);
                  if (e.gap >= 0) chk("gap", cyc - last_cyc, e.gap);
               end
               last_cyc = cyc;
            end
         end
      end
   end

   // Producers: retire the head word of every requester the DUT accepted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++)
            if (gnt_s[i] && pq[i].size() > 0) void'(pq[i].pop_front());
         update_inputs();
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n    = 1'b0;
      req      = '0;
      req_data = '0;
      req_last = '0;
      wfull    = 1'b0;
      en       = '1;
      gnt_s    = '0;

      // 1: single requester, 3-word packet
      do_reset();
      step();
      add_pkt(0, 'h10, 3);
      expect_w(0, 'h10, -1);
      expect_w(0, 'h11, 1);
      expect_w(0, 'h12, 1);
      wait_done(50);
      @(negedge clk);
      chk("idle_after_pkt", busy, 0);

      // 2: all requesting, 1-word packets -> 0,1,2,3,0
      do_reset();
      step();
      add_pkt(0, 'h20, 1);
      add_pkt(0, 'h24, 1);
      add_pkt(1, 'h21, 1);
      add_pkt(2, 'h22, 1);
      add_pkt(3, 'h23, 1);
      expect_w(0, 'h20, -1);
      expect_w(1, 'h21, 2);
      expect_w(2, 'h22, 2);
      expect_w(3, 'h23, 2);
      expect_w(0, 'h24, 2);
      wait_done(80);

      // 3: long packet on 2 cut into bursts of 4, interleaved with 1
      do_reset();
      step();
      add_pkt(1, 'h30, 1);
      add_pkt(1, 'h31, 1);
      add_pkt(1, 'h32, 1);
      add_pkt(2, 'h40, 10);
      expect_w(1, 'h30, -1);
      expect_w(2, 'h40, 2);
      expect_w(2, 'h41, 1);
      expect_w(2, 'h42, 1);
      expect_w(2, 'h43, 1);
      expect_w(1, 'h31, 2);
      expect_w(2, 'h44, 2);
      expect_w(2, 'h45, 1);
      expect_w(2, 'h46, 1);
      expect_w(2, 'h47, 1);
      expect_w(1, 'h32, 2);
      expect_w(2, 'h48, 2);
      expect_w(2, 'h49, 1);
      wait_done(120);

      // 4: wfull held 5 cycles mid-burst
      do_reset();
      step();
      base = wr_count;
      add_pkt(0, 'h50, 6);
      expect_w(0, 'h50, -1);
      expect_w(0, 'h51, 1);
      expect_w(0, 'h52, 6);
      expect_w(0, 'h53, 1);
      expect_w(0, 'h54, 2);
      expect_w(0, 'h55, 1);
      wait_writes(base + 2, 50);
      wfull = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("full_winc", winc, 0);
         chk("full_gnt",  gnt,  0);
         chk("full_busy", busy, 1);
         step();
      end
      wfull = 1'b0;
      wait_done(80);

      // 5: owner withdraws mid-burst
      do_reset();
      step();
      base = wr_count;
      add_pkt(0, 'h60, 5);
      add_pkt(1, 'h70, 1);
      expect_w(0, 'h60, -1);
      expect_w(0, 'h61, 1);
      expect_w(1, 'h70, 3);
      expect_w(0, 'h62, 2);
      expect_w(0, 'h63, 1);
      expect_w(0, 'h64, 1);
      wait_writes(base + 2, 50);
      en[0] = 1'b0;
      update_inputs();
      @(negedge clk);
      chk("withdraw_winc", winc, 0);
      wait_writes(base + 3, 50);
      en[0] = 1'b1;
      update_inputs();
      wait_done(80);

      // 6: reset during 2nd word of a burst, then priority restarts at 0
      do_reset();
      step();
      base = wr_count;
      add_pkt(1, 'h65, 1);
      expect_w(1, 'h65, -1);
      wait_writes(base + 1, 50);
      add_pkt(0, 'h80, 4);
      expect_w(0, 'h80, 2);
      wait_writes(base + 2, 50);
      chk("pre_rst_busy", busy, 1);
      do_reset();
      step();
      add_pkt(3, 'h93, 1);
      add_pkt(0, 'h90, 1);
      expect_w(0, 'h90, -1);
      expect_w(3, 'h93, 2);
      wait_done(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_afifo_wr_arbiter

`default_nettype wire
